selector_n_pipe: RTL and testbench

- Parametrised N-way, WIDTH-bit registered selector with a valid/ready handshake on both sides. It generalises the datapath 4:1 32-bit operand selector.
- Selection is captured together with the data, so a multicycle-CPU stage can stall downstream without losing a selected operand.
- A 2-entry skid buffer gives a full-rate, 1-cycle-latency path.
- An out-of-range Selection is flagged per beat.

---
 rtl/selector_n_pipe.sv | 119 +++++++++++
 tb/tb_selector_n_pipe.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/selector_n_pipe.sv
// selector_n_pipe: N-way WIDTH-bit registered selector with valid/ready on
// both sides. A main register M drives the outputs. A skid register S holds
// a second beat, so the block can accept one beat per cycle while InReady is
// registered.
module selector_n_pipe #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [N*WIDTH-1:0] DataIn,
  input  logic [SEL_W-1:0]   Selection,
  input  logic               InValid,
  output logic               InReady,
  output logic [WIDTH-1:0]   DataOut,
  output logic               SelError,
  output logic               OutValid,
  input  logic               OutReady
);

  // EMPTY: M and S invalid; ONE: only M valid; TWO: M and S valid.
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t           state, nextState;
  logic [WIDTH-1:0] mData, sData, pickData;
  logic             mErr, sErr, pickErr;
  logic             inReadyQ;
  logic             inFire, outFire;
  logic             loadM, loadS, moveS;

  // Select the channel. Any code >= N (including unused codes when N is not
  // a power of two) falls back to the last channel and is flagged.
  always_comb begin
    pickData = DataIn[(N-1)*WIDTH +: WIDTH];
    pickErr  = 1'b1;
    for (int unsigned k = 0; k < N; k++) begin
      if (32'(Selection) == k) begin
        pickData = DataIn[k*WIDTH +: WIDTH];
        pickErr  = 1'b0;
      end
    end
  end

  // Next state and register load controls for the two-entry skid buffer.
  always_comb begin
    nextState = state;
    loadM     = 1'b0;
    loadS     = 1'b0;
    moveS     = 1'b0;
    inFire    = InValid & inReadyQ;
    outFire   = (state != EMPTY) & OutReady;
    unique case (state)
      EMPTY: begin
        if (inFire) begin
          loadM     = 1'b1;
          nextState = ONE;
        end
      end
      ONE: begin
        if (inFire && outFire) begin
          loadM = 1'b1;
        end else if (inFire) begin
          loadS     = 1'b1;
          nextState = TWO;
        end else if (outFire) begin
          nextState = EMPTY;
        end
      end
      TWO: begin
        if (outFire) begin
          moveS     = 1'b1;
          nextState = ONE;
        end
      end
      default: nextState = EMPTY;
    endcase
  end

  // State register. InReady is registered from the next state, so it has no
  // combinational path from OutReady.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state    <= EMPTY;
      inReadyQ <= 1'b1;
    end else begin
      state    <= nextState;
      inReadyQ <= (nextState != TWO);
    end
  end

  // Datapath registers M and S.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      mData <= '0;
      mErr  <= 1'b0;
      sData <= '0;
      sErr  <= 1'b0;
    end else begin
      if (loadM) begin
        mData <= pickData;
        mErr  <= pickErr;
      end else if (moveS) begin
        mData <= sData;
        mErr  <= sErr;
      end
      if (loadS) begin
        sData <= pickData;
        sErr  <= pickErr;
      end
    end
  end

  assign DataOut  = mData;
  assign SelError = mErr;
  assign OutValid = (state != EMPTY);
  assign InReady  = inReadyQ;

endmodule

// File: tb/tb_selector_n_pipe.sv
// Testbench for selector_n_pipe. Two instances share the handshake signals:
// one with N=4 and one with N=3 (Selection=3 is out of range there). A
// queue-based model predicts the outputs of each instance on every cycle.
module tb_selector_n_pipe;

  localparam int W = 32;

  logic          clk;
  logic          Reset;
  logic [4*W-1:0] DataIn;
  logic [1:0]    Selection;
  logic          InValid;
  logic          OutReady;

  logic          inReady4, outValid4, selError4;
  logic [W-1:0]  dataOut4;
  logic          inReady3, outValid3, selError3;
  logic [W-1:0]  dataOut3;

  int passCount  = 0;
  int totalCount = 0;
  bit armed      = 0;

  logic [W:0] q4[$];
  logic [W:0] q3[$];

  selector_n_pipe #(.WIDTH(W), .N(4), .SEL_W(2)) dut4 (
    .CLK(clk), .Reset(Reset), .DataIn(DataIn), .Selection(Selection),
    .InValid(InValid), .InReady(inReady4), .DataOut(dataOut4),
    .SelError(selError4), .OutValid(outValid4), .OutReady(OutReady)
  );

  selector_n_pipe #(.WIDTH(W), .N(3), .SEL_W(2)) dut3 (
    .CLK(clk), .Reset(Reset), .DataIn(DataIn[3*W-1:0]), .Selection(Selection),
    .InValid(InValid), .InReady(inReady3), .DataOut(dataOut3),
    .SelError(selError3), .OutValid(outValid3), .OutReady(OutReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    totalCount++;
    if (act === exp) passCount++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Beat carried for a given channel count: {err, data}.
  function automatic logic [W:0] expectBeat(input int n, input logic [4*W-1:0] din,
                                            input logic [1:0] sel);
    int s;
    s = int'(sel);
    if (s < n) return {1'b0, din[s*W +: W]};
    return {1'b1, din[(n-1)*W +: W]};
  endfunction

  // Model: FIFO of at most two accepted beats per instance.
  always @(posedge clk) begin
    logic [W:0] tmp;
    bit inOk, outOk;
    if (Reset) begin
      q4.delete();
      q3.delete();
      armed = 1;
    end else begin
      inOk  = InValid && (q4.size() < 2);
      outOk = OutReady && (q4.size() > 0);
      if (outOk) tmp = q4.pop_front();
      if (inOk) q4.push_back(expectBeat(4, DataIn, Selection));
      inOk  = InValid && (q3.size() < 2);
      outOk = OutReady && (q3.size() > 0);
      if (outOk) tmp = q3.pop_front();
      if (inOk) q3.push_back(expectBeat(3, DataIn, Selection));
    end
  end

  // Compare both instances against the model every cycle after reset.
  always @(posedge clk) begin
    #1;
    if (armed) begin
      check("outValid4", 64'(outValid4), 64'(q4.size() > 0));
      check("inReady4", 64'(inReady4), 64'(q4.size() < 2));
      if (q4.size() > 0) begin
        check("dataOut4", 64'(dataOut4), 64'(q4[0][W-1:0]));
        check("selError4", 64'(selError4), 64'(q4[0][W]));
      end
      check("outValid3", 64'(outValid3), 64'(q3.size() > 0));
      check("inReady3", 64'(inReady3), 64'(q3.size() < 2));
      if (q3.size() > 0) begin
        check("dataOut3", 64'(dataOut3), 64'(q3[0][W-1:0]));
        check("selError3", 64'(selError3), 64'(q3[0][W]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [23:0] vPat;
    logic [23:0] rPat;
    vPat = 24'hB5E37D;
    rPat = 24'h6C9A5F;

    Reset     = 1'b1;
    InValid   = 1'b0;
    OutReady  = 1'b1;
    Selection = 2'd0;
    DataIn    = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    tick();
    tick();
    Reset = 1'b0;
    check("rst_outValid", 64'(outValid4), 64'd0);
    check("rst_dataOut", 64'(dataOut4), 64'd0);
    check("rst_selError", 64'(selError4), 64'd0);
    check("rst_inReady", 64'(inReady4), 64'd1);

    // Single beat, Selection=2.
    Selection = 2'd2;
    InValid   = 1'b1;
    tick();
    InValid = 1'b0;
    check("single_valid", 64'(outValid4), 64'd1);
    check("single_data", 64'(dataOut4), 64'h33333333);
    check("single_err", 64'(selError4), 64'd0);
    check("model_head", 64'(q4[0][W-1:0]), 64'h33333333);
    tick();
    check("single_gone", 64'(outValid4), 64'd0);

    // Streaming 0..3 at full rate.
    for (int i = 0; i < 4; i++) begin
      Selection = 2'(i);
      InValid   = 1'b1;
      tick();
      check("stream_data", 64'(dataOut4), 64'(32'h11111111 * (i + 1)));
      check("stream_ready", 64'(inReady4), 64'd1);
    end
    check("oor_data3", 64'(dataOut3), 64'h33333333);
    check("oor_err3", 64'(selError3), 64'd1);
    InValid = 1'b0;
    tick();

    // Backpressure with two beats, then a third offered while full.
    OutReady  = 1'b0;
    Selection = 2'd1;
    InValid   = 1'b1;
    tick();
    check("bp_ready1", 64'(inReady4), 64'd1);
    Selection = 2'd3;
    tick();
    check("bp_ready0", 64'(inReady4), 64'd0);
    check("bp_hold", 64'(dataOut4), 64'h22222222);
    Selection = 2'd0;
    tick();
    tick();
    check("bp_still", 64'(dataOut4), 64'h22222222);
    InValid  = 1'b0;
    OutReady = 1'b1;
    tick();
    check("bp_second", 64'(dataOut4), 64'h44444444);
    check("bp_ready_back", 64'(inReady4), 64'd1);
    check("bp_err3", 64'(selError3), 64'd1);
    tick();
    check("bp_drained", 64'(outValid4), 64'd0);

    // Out-of-range beat followed by an in-range one on the N=3 instance.
    Selection = 2'd3;
    InValid   = 1'b1;
    tick();
    Selection = 2'd0;
    tick();
    InValid = 1'b0;
    check("after_oor_err3", 64'(selError3), 64'd0);
    check("after_oor_data3", 64'(dataOut3), 64'h11111111);
    tick();

    // Reset while holding two beats.
    OutReady  = 1'b0;
    InValid   = 1'b1;
    Selection = 2'd0;
    tick();
    Selection = 2'd1;
    tick();
    InValid = 1'b0;
    Reset   = 1'b1;
    tick();
    Reset = 1'b0;
    check("rst2_valid", 64'(outValid4), 64'd0);
    check("rst2_data", 64'(dataOut4), 64'd0);
    check("rst2_ready", 64'(inReady4), 64'd1);
    OutReady = 1'b1;
    tick();
    tick();
    check("rst2_nostale", 64'(outValid4), 64'd0);

    // Reset coincident with InValid.
    Reset     = 1'b1;
    InValid   = 1'b1;
    Selection = 2'd2;
    tick();
    Reset   = 1'b0;
    InValid = 1'b0;
    tick();
    check("rst_in_drop", 64'(outValid4), 64'd0);

    // Mixed valid/ready patterns with per-cycle data.
    for (int i = 0; i < 24; i++) begin
      InValid   = vPat[i];
      OutReady  = rPat[i];
      Selection = 2'(i % 4);
      DataIn    = {32'hD000_0000 + 32'(i), 32'hC000_0000 + 32'(i),
                   32'hB000_0000 + 32'(i), 32'hA000_0000 + 32'(i)};
      tick();
    end
    InValid  = 1'b0;
    OutReady = 1'b1;
    tick();
    tick();
    tick();
    check("final_empty", 64'(outValid4), 64'd0);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
